// File: rtl/wave_acc_pkg.sv
// ============================================================================
// Module : wave_acc_pkg
// Brief  : Shared types and constants for the waveform accumulator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wave_acc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TRIG = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_FLUSH     = 3'd3,
        ST_EVAL      = 3'd4,
        ST_DRAIN     = 3'd5
    } state_t;

    // Cycles needed for the last S0 sample to reach the RAM write port.
    localparam int FLUSH_CYCLES = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/waveform_accumulator_ram.sv
// ============================================================================
// Module : acc_ram
// Brief  : Simple dual-port RAM, registered read with enable (holds when idle).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module acc_ram #(
    parameter int DEPTH  = 128,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_q;

endmodule

`default_nettype wire

// File: rtl/waveform_accumulator.sv
// ============================================================================
// Module : waveform_accumulator
// Brief  : Sums NUM_EVENTS triggered records element-wise, then streams the
//          result out over valid/ready. Define WAVE_ACC_SATURATE_EN to clamp.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module waveform_accumulator
    import wave_acc_pkg::*;
#(
    parameter int SAMPLE_W = 8,
    parameter int ACC_W    = 16,
    parameter int REC_LEN  = 128,
    parameter int EVT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                trig,
    input  logic [EVT_W-1:0]    num_events,
    output logic [ACC_W-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                overflow
);

    localparam int ADDR_W = clog2(REC_LEN);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REC_LEN - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   idx_q, rd_ptr_q, s0_addr_q, s1_addr_q;
    logic [EVT_W-1:0]    evt_q, nev_q;
    logic [1:0]          flush_q;
    logic                busy_q, ovf_q, rd_done_q;
    logic                s0_vld_q, s1_vld_q, pf_vld_q, pf_last_q;
    logic                out_valid_q, out_last_q;
    logic [SAMPLE_W-1:0] s0_smp_q;
    logic [ACC_W-1:0]    s1_sum_q, out_data_q, ram_rd;

    logic                accept_d, cap_en_d, pf_take_d, drain_rd_d, rd_en_d;
    logic                carry_d;
    logic [ADDR_W-1:0]   cap_addr_d, rd_addr_d;
    logic [ACC_W-1:0]    base_d, sum_d, res_d;

    assign accept_d   = trig && (state_q == ST_IDLE || state_q == ST_WAIT_TRIG);
    assign cap_en_d   = accept_d || (state_q == ST_CAPTURE);
    assign cap_addr_d = accept_d ? '0 : idx_q;
    // The prefetch slot is the RAM output register itself; refill it the
    // same cycle it is handed to the output register.
    assign pf_take_d  = pf_vld_q && (!out_valid_q || out_ready);
    assign drain_rd_d = (state_q == ST_DRAIN) && !rd_done_q && (!pf_vld_q || pf_take_d);
    assign rd_en_d    = cap_en_d || drain_rd_d;
    assign rd_addr_d  = cap_en_d ? cap_addr_d : rd_ptr_q;

    // S1: first event of a run ignores whatever the RAM holds.
    assign base_d = (evt_q == '0) ? '0 : ram_rd;
    assign {carry_d, sum_d} = {1'b0, base_d} + (ACC_W + 1)'(s0_smp_q);
`ifdef WAVE_ACC_SATURATE_EN
    assign res_d = carry_d ? '1 : sum_d;
`else
    assign res_d = sum_d;
`endif

    acc_ram #(
        .DEPTH  (REC_LEN),
        .WIDTH  (ACC_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (s1_vld_q),
        .wr_addr_i (s1_addr_q),
        .wr_data_i (s1_sum_q),
        .rd_en_i   (rd_en_d),
        .rd_addr_i (rd_addr_d),
        .rd_data_o (ram_rd)
    );

    always_ff @(posedge clk) begin
        s0_smp_q  <= sample_in;
        s0_addr_q <= cap_addr_d;
        s1_sum_q  <= res_d;
        s1_addr_q <= s0_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            evt_q       <= '0;
            nev_q       <= EVT_W'(1);
            flush_q     <= '0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            s0_vld_q    <= 1'b0;
            s1_vld_q    <= 1'b0;
            rd_ptr_q    <= '0;
            rd_done_q   <= 1'b0;
            pf_vld_q    <= 1'b0;
            pf_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s0_vld_q <= cap_en_d;
            s1_vld_q <= s0_vld_q;
            if (s0_vld_q && carry_d) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (trig) begin
                        nev_q   <= (num_events == '0) ? EVT_W'(1) : num_events;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        idx_q   <= ADDR_W'(1);
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (trig) begin
                        idx_q   <= ADDR_W'(1);
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (idx_q == LAST_IDX) begin
                        flush_q <= '0;
                        state_q <= ST_FLUSH;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_q == 2'(FLUSH_CYCLES - 1)) begin
                        state_q <= ST_EVAL;
                    end else begin
                        flush_q <= flush_q + 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (evt_q == nev_q - 1'b1) begin
                        rd_ptr_q  <= '0;
                        rd_done_q <= 1'b0;
                        pf_vld_q  <= 1'b0;
                        state_q   <= ST_DRAIN;
                    end else begin
                        evt_q   <= evt_q + 1'b1;
                        state_q <= ST_WAIT_TRIG;
                    end
                end
                ST_DRAIN: begin
                    if (drain_rd_d) begin
                        rd_ptr_q  <= rd_ptr_q + 1'b1;
                        rd_done_q <= (rd_ptr_q == LAST_IDX);
                        pf_last_q <= (rd_ptr_q == LAST_IDX);
                    end
                    pf_vld_q <= drain_rd_d || (pf_vld_q && !pf_take_d);
                    if (pf_take_d) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= ram_rd;
                        out_last_q  <= pf_last_q;
                    end else if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                    if (out_valid_q && out_ready && out_last_q) begin
                        evt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_waveform_accumulator.sv
// ============================================================================
// Module : tb_waveform_accumulator
// Brief  : Scoreboard bench for waveform_accumulator (REC_LEN=8, ACC_W=9).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_waveform_accumulator;

    localparam int SAMPLE_W = 8;
    localparam int ACC_W    = 9;
    localparam int REC_LEN  = 8;
    localparam int EVT_W    = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [SAMPLE_W-1:0] sample_in;
    logic                trig;
    logic [EVT_W-1:0]    num_events;
    logic [ACC_W-1:0]    out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic                busy;
    logic                overflow;

    typedef struct packed {
        logic [ACC_W-1:0] d;
        logic             l;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ready_mode = 0;
    logic             held_v = 1'b0;
    logic [ACC_W-1:0] held_d;
    logic             held_l;

    waveform_accumulator #(
        .SAMPLE_W (SAMPLE_W),
        .ACC_W    (ACC_W),
        .REC_LEN  (REC_LEN),
        .EVT_W    (EVT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_in  (sample_in),
        .trig       (trig),
        .num_events (num_events),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int d, input bit l);
        exp_t e;
        e.d = ACC_W'(d);
        e.l = l;
        sb.push_back(e);
    endtask

    // One triggered record: index i carries base + i*step.
    task automatic send_rec(input int base, input int step, input bit extra, input int gap);
        trig      = 1'b1;
        sample_in = SAMPLE_W'(base);
        tick();
        check_val("busy_on", busy, 1);
        for (int i = 1; i < REC_LEN; i++) begin
            sample_in = SAMPLE_W'(base + i * step);
            trig      = extra && (i == 3);
            tick();
        end
        trig = 1'b0;
        for (int i = 0; i < gap; i++) begin
            sample_in = SAMPLE_W'($urandom);
            tick();
        end
    endtask

    task automatic wait_drain(input bit extra, input logic exp_ovf);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            trig = extra && (n % 3 == 1);
            tick();
            n++;
        end
        trig = 1'b0;
        if (n >= 300) begin
            check_val("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        check_val("busy_off", busy, 0);
        check_val("valid_off", out_valid, 0);
        check_val("overflow", overflow, exp_ovf);
        repeat (10) tick();
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) out_ready = 1'b1;
            else                 out_ready = ~out_ready;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check_val("hold_valid", out_valid, 1);
                    check_val("hold_data", out_data, held_d);
                    check_val("hold_last", out_last, held_l);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check_val("extra_word", out_data, 32'hFFFF_FFFF);
                    end else begin
                        mon_e = sb.pop_front();
                        check_val("data", out_data, mon_e.d);
                        check_val("last", out_last, mon_e.l);
                    end
                end
                held_v = out_valid && !out_ready;
                held_d = out_data;
                held_l = out_last;
            end
        end
    end

    initial begin
        rst        = 1'b1;
        trig       = 1'b0;
        sample_in  = '0;
        num_events = 8'd1;
        repeat (3) tick();
        check_val("rst_valid", out_valid, 0);
        check_val("rst_last", out_last, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick();

        // Single event ramp.
        num_events = 8'd1;
        for (int i = 0; i < REC_LEN; i++) push_word(i, i == REC_LEN - 1);
        send_rec(0, 1, 1'b0, 0);
        wait_drain(1'b0, 1'b0);

        // Three events of constant 5; num_events changed mid-run.
        num_events = 8'd3;
        for (int i = 0; i < REC_LEN; i++) push_word(15, i == REC_LEN - 1);
        send_rec(5, 0, 1'b0, 15);
        num_events = 8'd7;
        send_rec(5, 0, 1'b0, 15);
        send_rec(5, 0, 1'b0, 0);
        wait_drain(1'b0, 1'b0);

        // Same with a stalling consumer.
        num_events = 8'd3;
        ready_mode = 1;
        for (int i = 0; i < REC_LEN; i++) push_word(15, i == REC_LEN - 1);
        for (int e = 0; e < 3; e++) send_rec(5, 0, 1'b0, (e == 2) ? 0 : 15);
        wait_drain(1'b0, 1'b0);
        ready_mode = 0;

        // Overflow: 3 x 255 into a 9-bit accumulator.
        for (int i = 0; i < REC_LEN; i++) begin
`ifdef WAVE_ACC_SATURATE_EN
            push_word(511, i == REC_LEN - 1);
`else
            push_word(253, i == REC_LEN - 1);
`endif
        end
        for (int e = 0; e < 3; e++) send_rec(255, 0, 1'b0, (e == 2) ? 0 : 15);
        wait_drain(1'b0, 1'b1);

        // Stray triggers during capture and drain are ignored.
        num_events = 8'd2;
        for (int i = 0; i < REC_LEN; i++) push_word(2 * (1 + 3 * i), i == REC_LEN - 1);
        send_rec(1, 3, 1'b1, 15);
        send_rec(1, 3, 1'b1, 0);
        wait_drain(1'b1, 1'b0);

        // Reset during the third event, then a clean single-event run.
        num_events = 8'd3;
        send_rec(40, 1, 1'b0, 15);
        send_rec(40, 1, 1'b0, 15);
        trig      = 1'b1;
        sample_in = 8'd40;
        tick();
        trig = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_valid", out_valid, 0);
        tick();
        num_events = 8'd1;
        for (int i = 0; i < REC_LEN; i++) push_word(10 + i, i == REC_LEN - 1);
        send_rec(10, 1, 1'b0, 0);
        wait_drain(1'b0, 1'b0);

        repeat (10) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/waveform_accumulator.md
Name: waveform_accumulator

Overview:
- Parametrised signal averager: sums NUM_EVENTS triggered records of REC_LEN samples, element by element, into an on-chip accumulation RAM.
- After the last event, streams the summed record out over a valid/ready interface, then re-arms.
- Sits between the ADC capture path (fast clk domain) and the downstream transfer FIFO/packetiser.
- Runtime event count; generic sample width, accumulator width and record length.

Parameters:
- SAMPLE_W, 8, input sample width (unsigned).
- ACC_W, 16, accumulator/output width; must be >= SAMPLE_W.
- REC_LEN, 128, samples per record; >= 4.
- EVT_W, 8, width of num_events and the internal event counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  SAMPLE_W  ADC sample, valid every cycle.
- trig  in  1  capture strobe; single-cycle or level, edge not required.
- num_events  in  EVT_W  events per accumulation; latched on first trigger of a run; 0 treated as 1.
- out_data  out  ACC_W  accumulated sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  marks index REC_LEN-1.
- busy  out  1  high from first accepted trig until last word is drained.
- overflow  out  1  sticky; a sum exceeded 2^ACC_W-1 during the current/last run.

Behaviour:
- Reset values: out_valid=0, out_last=0, busy=0, overflow=0, event_cnt=0, state=IDLE. RAM is not cleared.
- States:
  - IDLE: trig -> CAPTURE; latch num_events; clear overflow.
  - WAIT_TRIG: trig -> CAPTURE.
  - CAPTURE: REC_LEN cycles, idx 0..REC_LEN-1 -> FLUSH.
  - FLUSH: 2 cycles to drain RMW pipeline -> EVAL.
  - EVAL: 1 cycle; if event_cnt==num_events_l-1 -> DRAIN, else event_cnt++ -> WAIT_TRIG.
  - DRAIN: emits REC_LEN words -> IDLE, event_cnt=0.
- Sample indexing: the sample present in the cycle trig is accepted is index 0; following cycles give indices 1..REC_LEN-1.
- RMW pipeline, 3 stages:
  - S0: register sample/idx; issue RAM read.
  - S1: sum = (event_cnt==0 ? 0 : ram_q) + zero-extended sample, ACC_W bits.
  - S2: write sum back.
- No read-during-write hazard exists: within a record, addresses are distinct; FLUSH guarantees all writes land before the next trig is accepted.
- trig is ignored in CAPTURE, FLUSH, EVAL and DRAIN; no queuing, no event counted.
- Overflow: set when the carry out of the ACC_W-bit add is 1.
- DRAIN handshake:
  - A word transfers when out_valid & out_ready.
  - While out_valid & !out_ready, out_data/out_last are held stable.
  - out_valid may rise no earlier than 1 cycle after entering DRAIN (RAM read latency).
  - Zero-bubble throughput at out_ready=1 after the first word (prefetch register).
  - out_last=1 only on index REC_LEN-1.
- Reset mid-operation: any state -> IDLE in the next cycle; an in-flight RAM write may complete or be dropped. The next run's event 0 overwrites all RAM words, so no stale data is visible.
- num_events changes mid-run have no effect until the next IDLE->CAPTURE.

Optional Feature:
- WAVE_ACC_SATURATE_EN defined: S1 result clamps to 2^ACC_W-1 on carry; overflow is set.
- Not defined: result wraps modulo 2^ACC_W; overflow is still set.

Decomposition:
- Package wave_acc_pkg:
  - state enum (IDLE, WAIT_TRIG, CAPTURE, FLUSH, EVAL, DRAIN).
  - FLUSH_CYCLES=2.
  - function clog2 for ADDR_W.
- Sub-module acc_ram: simple dual-port, 1 write port, 1 read port, registered read (1-cycle), REC_LEN x ACC_W, inferable as block RAM.
- Top level contains the FSM, counters, RMW pipeline and output prefetch.

Test Plan (bench REC_LEN=8 unless noted):
- num_events=1, sample ramp 0..7 after trig -> DRAIN outputs 0,1,...,7; out_last only on 7; busy falls after last transfer.
- num_events=3, sample constant 5 for each of 3 triggers -> outputs eight words of 15; overflow=0.
- Same as previous, out_ready toggling 1,0,1,0 -> exactly eight 15s, no duplicates or drops; data stable while stalled.
- ACC_W=9, num_events=3, sample 255 -> with macro: 511 and overflow=1; without macro: 253 and overflow=1.
- Extra trig pulses mid-CAPTURE and mid-DRAIN, num_events=2 -> ignored; output equals 2x per-index sample; exactly 8 words.
- rst asserted during event 2 of 3, then num_events=1 ramp 10..17 -> busy=0 and out_valid=0 after reset; next drain outputs 10..17 with no residue.
